// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: loader state encoding,
// program-size limit and the HLT opcode.
package mips32_pkg;

   localparam int         MAX_WORDS_DEF = 1024;
   localparam logic [5:0] OP_HLT        = 6'h3f;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } ld_state_e;

   function automatic logic is_hlt(input logic [31:0] w);
      return w[31:26] == OP_HLT;
   endfunction

endpackage

// File: rtl/mips32_byte_packer.sv
// Assembles four bytes (MSB first) into a 32-bit word.
// Ports: clk_i, rst_ni, clr_i, byte_valid_i, byte_i -> word_o, word_valid_o
module mips32_byte_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [31:0] shift_q;
   logic [1:0]  cnt_q;
   logic        wv_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
         wv_q    <= 1'b0;
      end else begin
         wv_q <= 1'b0;
         if (clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
         end else if (byte_valid_i) begin
            shift_q <= {shift_q[23:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
            // pulse lands the cycle after the 4th byte
            wv_q    <= (cnt_q == 2'd3);
         end
      end
   end

   assign word_o       = shift_q;
   assign word_valid_o = wv_q;

endmodule

// File: rtl/mips32_prog_loader.sv
// Streams a length-prefixed, XOR-checked program into
// instruction memory and releases the mips32 core when done.
// Ports: clk1, reset_n, start, byte_valid/byte_data/byte_ready,
//        mem_we/mem_addr/mem_wdata, core_hold, core_go, done, err
module mips32_prog_loader
   import mips32_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk1,
   input  logic              reset_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_go,
   output logic              done,
   output logic              err
);

   ld_state_e         state_q, state_d;
   logic [7:0]        len_hi_q;
   logic [15:0]       len_q;
   logic [17:0]       cnt_q;
   logic [7:0]        csum_q;
   logic [ADDR_W-1:0] addr_q;
   logic              go_q;

   logic        accept;
   logic [15:0] n_w;
   logic        len_ok;
   logic        last_byte;
   logic        enter_len;
   logic        pk_valid;
   logic        pk_wv;
   logic [31:0] pk_word;

   assign accept    = byte_valid & byte_ready;
   assign n_w       = {len_hi_q, byte_data};
   assign len_ok    = (n_w != 16'd0) &&
                      ({16'd0, n_w} <= 32'(MAX_WORDS));
   assign last_byte = (cnt_q == ({len_q, 2'b00} - 18'd1));
   assign enter_len = (state_q != S_LEN_HI) &&
                      (state_d == S_LEN_HI);
   assign pk_valid  = accept && (state_q == S_DATA);

   mips32_byte_packer u_packer (
      .clk_i        (clk1),
      .rst_ni       (reset_n),
      .clr_i        (enter_len),
      .byte_valid_i (pk_valid),
      .byte_i       (byte_data),
      .word_o       (pk_word),
      .word_valid_o (pk_wv)
   );

   always_ff @(posedge clk1 or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR:
            if (start) state_d = S_LEN_HI;
         S_LEN_HI:
            if (accept) state_d = S_LEN_LO;
         S_LEN_LO:
            if (accept) state_d = len_ok ? S_DATA : S_ERR;
         S_DATA:
            if (accept && last_byte) state_d = S_CSUM;
         S_CSUM:
            if (accept)
               state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      core_hold  = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      unique case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: byte_ready = 1'b1;
         S_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
         end
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk1 or negedge reset_n) begin
      if (!reset_n) begin
         len_hi_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         csum_q   <= '0;
         addr_q   <= '0;
         go_q     <= 1'b0;
      end else begin
         go_q <= (state_q == S_CSUM) && (state_d == S_DONE);
         if (enter_len) begin
            cnt_q  <= '0;
            csum_q <= '0;
            addr_q <= '0;
         end else begin
            if (accept && state_q == S_LEN_HI) len_hi_q <= byte_data;
            if (accept && state_q == S_LEN_LO) len_q    <= n_w;
            if (pk_valid) begin
               cnt_q  <= cnt_q + 18'd1;
               csum_q <= csum_q ^ byte_data;
            end
            // index stops at N-1 after the final write
            if (pk_wv && (17'(addr_q) + 17'd1 < {1'b0, len_q}))
               addr_q <= addr_q + 1'b1;
         end
      end
   end

   assign mem_we    = pk_wv;
   assign mem_addr  = addr_q;
   assign mem_wdata = pk_word;
   assign core_go   = go_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Randomised bench for mips32_prog_loader against a
// stream-level reference model.
module tb_mips32_prog_loader;

   logic        clk1 = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_hold;
   logic        core_go;
   logic        done;
   logic        err;

   mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
      .clk1       (clk1),
      .reset_n    (reset_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_hold  (core_hold),
      .core_go    (core_go),
      .done       (done),
      .err        (err)
   );

   always #5 clk1 = ~clk1;

   int n_tests = 0;
   int n_fail  = 0;
   int go_cnt  = 0;
   logic [9:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   always @(negedge clk1) begin
      if (reset_n) begin
         if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
         end
         if (core_go) go_cnt++;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int pct);
      int  tries = 0;
      bit  acc = 0;
      while (!acc && tries < 1000) begin
         @(negedge clk1);
         byte_data  = b;
         byte_valid = ($urandom_range(99) < pct);
         acc = byte_valid && byte_ready;
         @(posedge clk1);
         #1 byte_valid = 1'b0;
         tries++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      go_cnt = 0;
   endtask

   task automatic run_load(input logic [31:0] words[$],
                           input int n,
                           input logic [7:0] cx,
                           input int pct,
                           input bit mid_start,
                           input string tag);
      bit         bad;
      bit         exp_done;
      logic [7:0] cs;
      logic [15:0] nn;
      logic [31:0] w;
      int         nexp;
      bad = (n == 0) || (n > 1024);
      cs  = 8'h00;
      foreach (words[i]) begin
         w  = words[i];
         cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      end
      nn = n[15:0];
      clear_mon();
      pulse_start();
      send_byte(nn[15:8], pct);
      send_byte(nn[7:0], pct);
      if (!bad) begin
         foreach (words[i]) begin
            w = words[i];
            for (int j = 3; j >= 0; j--) begin
               send_byte(w[8*j +: 8], pct);
               if (mid_start && i == 0 && j == 2) pulse_start();
            end
         end
         send_byte(cs ^ cx, pct);
      end
      repeat (3) @(negedge clk1);
      nexp     = bad ? 0 : n;
      exp_done = !bad && (cx == 8'h00);
      chk({tag, "_nwr"}, wr_data.size(), nexp);
      for (int i = 0; i < wr_data.size() && i < words.size(); i++) begin
         chk({tag, "_addr"}, 32'(wr_addr[i]), i);
         chk({tag, "_data"}, wr_data[i], words[i]);
      end
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      chk({tag, "_err"}, 32'(err), 32'(!exp_done));
      chk({tag, "_hold"}, 32'(core_hold), 32'(!exp_done));
      chk({tag, "_go"}, go_cnt, exp_done ? 1 : 0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, 32'(byte_ready), 0);
      chk({tag, "_we"},    32'(mem_we), 0);
      chk({tag, "_addr"},  32'(mem_addr), 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_hold"},  32'(core_hold), 1);
      chk({tag, "_go"},    32'(core_go), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_err"},   32'(err), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prog[$];
      logic [31:0] q[$];
      logic [31:0] w;
      int          n;
      logic [7:0]  cx;

      prog = '{32'h28010078, 32'h0c631800, 32'h20220000,
               32'h0c631800, 32'h2842002d, 32'h0c631800,
               32'h24220001, 32'hfc000000};

      repeat (2) @(negedge clk1);
      chk_reset_outs("rst");
      reset_n = 1'b1;
      @(negedge clk1);

      run_load(prog, 8, 8'h00, 100, 0, "prog");
      run_load(prog, 8, 8'h01, 100, 0, "csum");

      q.delete();
      run_load(q, 0, 8'h00, 100, 0, "n0");
      run_load(q, 1025, 8'h00, 100, 0, "n1025");

      q.delete();
      q.push_back(32'hfc000000);
      run_load(q, 1, 8'h00, 50, 0, "bp");

      run_load(prog, 8, 8'h00, 100, 1, "midstart");

      // restart from DONE: hold must rise on the start edge
      pulse_start();
      chk("restart_hold", 32'(core_hold), 1);
      chk("restart_done", 32'(done), 0);
      chk("restart_ready", 32'(byte_ready), 1);
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back($urandom);
      run_load(q, 3, 8'h00, 80, 0, "restart");

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 6);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back($urandom);
         cx = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255))
                                        : 8'h00;
         run_load(q, n, cx, $urandom_range(30, 100), 0, "rand");
      end

      // reset after 6 of 12 data bytes
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back($urandom);
      clear_mon();
      pulse_start();
      send_byte(8'h00, 100);
      send_byte(8'h03, 100);
      for (int k = 0; k < 6; k++) begin
         w = q[k / 4];
         send_byte(w[8*(3 - k % 4) +: 8], 100);
      end
      reset_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      chk("midrst_nwr", wr_data.size(), 1);
      if (wr_data.size() > 0) chk("midrst_w0", wr_data[0], q[0]);
      @(negedge clk1) reset_n = 1'b1;
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back($urandom);
      run_load(q, 3, 8'h00, 100, 0, "postrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
